// File: rtl/gp_reg_arb.sv
// Round-robin arbiter that shares one general-purpose register write port among PA_NREQ requesters.
// Optional acknowledge timeout is compiled in with `define GP_ARB_TMO_EN.
module gp_reg_arb #(
    parameter int PA_DATA = 32,
    parameter int PA_HL   = 2,
    parameter int PA_NREQ = 4,
    parameter int PA_ADDR = 4,
    parameter int PA_TMO  = 16
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic [PA_NREQ-1:0]         req_vld,
    input  logic [PA_NREQ-1:0]         req_clr,
    input  logic [PA_NREQ*PA_ADDR-1:0] req_addr,
    input  logic [PA_NREQ*PA_DATA-1:0] req_data,
    input  logic [PA_NREQ*PA_HL-1:0]   req_hl,
    output logic [PA_NREQ-1:0]         req_gnt,
    output logic [PA_NREQ-1:0]         req_done,
    output logic [PA_NREQ-1:0]         req_err,
    output logic [PA_ADDR-1:0]         reg_sel,
    output logic [PA_DATA-1:0]         reg_data,
    output logic [PA_HL-1:0]           reg_hl,
    output logic                       reg_wr,
    output logic                       reg_clr,
    input  logic                       reg_wr_ack,
    output logic                       busy
);

    localparam int PW = (PA_NREQ > 1) ? $clog2(PA_NREQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, CLR_WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        gidx_q, gidx_d;
    logic                 clr_q, clr_d;
    logic [PA_NREQ-1:0]   gnt_q, gnt_d;
    logic [PA_NREQ-1:0]   done_q, done_d;
    logic [PA_NREQ-1:0]   err_q, err_d;
    logic [PA_ADDR-1:0]   sel_q, sel_d;
    logic [PA_DATA-1:0]   data_q, data_d;
    logic [PA_HL-1:0]     hl_q, hl_d;
    logic                 wr_q, wr_d;
    logic                 rclr_q, rclr_d;
    logic                 busy_q, busy_d;

    logic                 found;
    logic [PW-1:0]        win;
    logic                 tmo_hit;

    // First requesting index at or above the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < PA_NREQ; k++) begin
            if (!found && req_vld[(int'(ptr_q) + k) % PA_NREQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + k) % PA_NREQ);
            end
        end
    end

`ifdef GP_ARB_TMO_EN
    localparam int TW = $clog2(PA_TMO + 1);

    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = '0;
        if (state_q == WAIT_ACK) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end

    assign tmo_hit = (tmo_q == TW'(PA_TMO));
`else
    logic unused_tmo;
    assign unused_tmo = (PA_TMO != 0);
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        clr_d   = clr_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        sel_d   = sel_q;
        data_d  = data_q;
        hl_d    = hl_q;
        wr_d    = 1'b0;
        rclr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d     = win;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    clr_d      = req_clr[win];
                    sel_d      = req_addr[win*PA_ADDR +: PA_ADDR];
                    // A clear carries no payload, so the previous data/hl stay on the bus.
                    if (!req_clr[win]) begin
                        data_d = req_data[win*PA_DATA +: PA_DATA];
                        hl_d   = req_hl[win*PA_HL +: PA_HL];
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // First cycle launches the strobe, second cycle lets it be seen, then move on.
                if (wr_q || rclr_q) begin
                    state_d = clr_q ? CLR_WAIT : WAIT_ACK;
                end else begin
                    wr_d   = !clr_q;
                    rclr_d = clr_q;
                end
            end
            WAIT_ACK: begin
                if (reg_wr_ack) begin
                    done_d[gidx_q] = 1'b1;
                    state_d        = DONE;
                end else if (tmo_hit) begin
                    err_d[gidx_q] = 1'b1;
                    state_d       = DONE;
                end
            end
            CLR_WAIT: begin
                done_d[gidx_q] = 1'b1;
                state_d        = DONE;
            end
            DONE: begin
                gnt_d   = '0;
                ptr_d   = (gidx_q == PW'(PA_NREQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            clr_q   <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            hl_q    <= '0;
            wr_q    <= 1'b0;
            rclr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            clr_q   <= clr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            hl_q    <= hl_d;
            wr_q    <= wr_d;
            rclr_q  <= rclr_d;
            busy_q  <= busy_d;
        end
    end

    assign req_gnt  = gnt_q;
    assign req_done = done_q;
    assign req_err  = err_q;
    assign reg_sel  = sel_q;
    assign reg_data = data_q;
    assign reg_hl   = hl_q;
    assign reg_wr   = wr_q;
    assign reg_clr  = rclr_q;
    assign busy     = busy_q;

endmodule
